// File: rtl/counter_run_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// counter_run_ctrl_pkg
//
// Shared types and constants for the run/pause/clear/speed controller.
//   run_state_t : controller FSM states. The encoding is visible on o_State.
//   SPEED_W     : width of the speed index (speeds 0..3).
//   STATE_W     : width of the FSM state encoding.
//   speed_inc() : advances the speed index. It wraps 3 -> 0 by natural overflow.
//
// Optional feature macro: COUNTER_RUN_CTRL_STEP_EN. The package does not use it.
// The macro is listed here so that every file of the block names it.
// -----------------------------------------------------------------------------
package counter_run_ctrl_pkg;

    localparam int SPEED_W = 2;
    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_CLEAR  = 2'd3
    } run_state_t;

    function automatic logic [SPEED_W-1:0] speed_inc(input logic [SPEED_W-1:0] speed);
        return speed + SPEED_W'(1);
    endfunction

endpackage

// File: rtl/counter_run_ctrl_switch_debounce.sv
// -----------------------------------------------------------------------------
// switch_debounce
//
// Input path for one raw switch. The path has three stages:
//   1. A 2-FF synchronizer.
//   2. A debouncer. The debounced level follows the synchronized level only
//      after the two have differed for DEBOUNCE_LIMIT consecutive cycles.
//      The counter clears whenever the two levels agree, so shorter glitches
//      never reach the debounced level.
//   3. A registered press strobe. It is one cycle wide and fires on each
//      debounced 0->1 transition.
//
// Ports:
//   i_Clk      in   system clock
//   i_Rst_L    in   asynchronous active-low reset
//   i_Switch   in   raw, asynchronous switch level
//   o_Press    out  one-cycle strobe on each debounced rising edge
//
// Optional feature macro: COUNTER_RUN_CTRL_STEP_EN. This module does not use it.
// -----------------------------------------------------------------------------
module switch_debounce #(
    parameter int DEBOUNCE_LIMIT = 250_000
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Switch,
    output logic o_Press
);

    // The counter must reach DEBOUNCE_LIMIT-1. The +1 keeps the width at
    // least 1 bit, even when DEBOUNCE_LIMIT is 1.
    localparam int CNT_W = $clog2(DEBOUNCE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);

    logic             sync_0;
    logic             sync_1;
    logic             deb_q;
    logic             deb_d;
    logic [CNT_W-1:0] cnt_q;
    logic             press_q;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sync_0  <= 1'b0;
            sync_1  <= 1'b0;
            deb_q   <= 1'b0;
            deb_d   <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync_0 <= i_Switch;
            sync_1 <= sync_0;

            if (sync_1 == deb_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                // This is the DEBOUNCE_LIMIT-th consecutive cycle of disagreement.
                deb_q <= sync_1;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end

            // The edge register turns the debounced rise into a one-cycle strobe.
            deb_d   <= deb_q;
            press_q <= deb_q & ~deb_d;
        end
    end

    assign o_Press = press_q;

endmodule

// File: rtl/counter_run_ctrl.sv
// -----------------------------------------------------------------------------
// counter_run_ctrl
//
// Run/pause/clear/speed controller for a 4-bit LED counter.
// Three raw switches are debounced into press strobes, and those strobes
// drive a 4-state FSM:
//   Switch 1 : IDLE -> RUN, RUN <-> PAUSED
//   Switch 2 : any state -> CLEAR. CLEAR lasts one cycle and then returns
//              to IDLE. A Switch 2 press wins over a Switch 1 press in the
//              same cycle.
//   Switch 3 : cycles the speed index 0..3. The tick period is
//              HALF_SECOND >> speed. The prescaler reloads to 0 on the change.
// In RUN, a prescaler counts 0..PERIOD-1 and issues a one-cycle o_Tick each
// time it wraps.
//
// Ports:
//   i_Clk       in   system clock (25 MHz)
//   i_Rst_L     in   asynchronous active-low reset
//   i_Switch_1  in   raw run/pause switch
//   i_Switch_2  in   raw clear switch
//   i_Switch_3  in   raw speed switch
//   o_Tick      out  one-cycle increment strobe
//   o_Clear     out  one-cycle clear strobe. It is high exactly while in CLEAR.
//   o_Speed     out  current speed index
//   o_State     out  FSM state (IDLE=0, RUN=1, PAUSED=2, CLEAR=3)
//
// Optional feature macro: COUNTER_RUN_CTRL_STEP_EN.
//   When it is defined, a Switch 3 press while PAUSED single-steps the
//   counter: it emits exactly one o_Tick on the next cycle, and the speed
//   and prescaler stay unchanged.
//   When it is undefined, Switch 3 always cycles the speed.
// -----------------------------------------------------------------------------
module counter_run_ctrl
    import counter_run_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_LIMIT = 250_000,
    parameter int HALF_SECOND    = 12_500_000
) (
    input  logic               i_Clk,
    input  logic               i_Rst_L,
    input  logic               i_Switch_1,
    input  logic               i_Switch_2,
    input  logic               i_Switch_3,
    output logic               o_Tick,
    output logic               o_Clear,
    output logic [SPEED_W-1:0] o_Speed,
    output logic [STATE_W-1:0] o_State
);

    localparam int PRE_W = $clog2(HALF_SECOND);

    logic press_1;
    logic press_2;
    logic press_3;

    run_state_t         state_q;
    run_state_t         state_next;
    logic [SPEED_W-1:0] speed_q;
    logic [PRE_W-1:0]   presc_q;
    logic [PRE_W-1:0]   presc_last;
    logic               tick_q;
    logic               clear_q;
    logic               speed_cycle;
    logic               step_req;
    logic               run_adv;

    // ---------------------------------------------------------------- inputs
    switch_debounce #(.DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)) u_deb_1 (
        .i_Clk    (i_Clk),
        .i_Rst_L  (i_Rst_L),
        .i_Switch (i_Switch_1),
        .o_Press  (press_1)
    );

    switch_debounce #(.DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)) u_deb_2 (
        .i_Clk    (i_Clk),
        .i_Rst_L  (i_Rst_L),
        .i_Switch (i_Switch_2),
        .o_Press  (press_2)
    );

    switch_debounce #(.DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)) u_deb_3 (
        .i_Clk    (i_Clk),
        .i_Rst_L  (i_Rst_L),
        .i_Switch (i_Switch_3),
        .o_Press  (press_3)
    );

    // ------------------------------------------------------- next-state logic
    always_comb begin
        state_next = state_q;
        if (press_2) begin
            state_next = ST_CLEAR;
        end else begin
            case (state_q)
                ST_IDLE:   if (press_1) state_next = ST_RUN;
                ST_RUN:    if (press_1) state_next = ST_PAUSED;
                ST_PAUSED: if (press_1) state_next = ST_RUN;
                ST_CLEAR:  state_next = ST_IDLE;
                default:   state_next = ST_IDLE;
            endcase
        end
    end

    // Decides what a Switch 3 press does in the current state.
    always_comb begin
        speed_cycle = 1'b0;
        step_req    = 1'b0;
`ifdef COUNTER_RUN_CTRL_STEP_EN
        if (press_3) begin
            if (state_q == ST_PAUSED) begin
                // Step only if the controller stays paused. A simultaneous
                // resume or clear takes precedence.
                step_req = (state_next == ST_PAUSED);
            end else begin
                speed_cycle = 1'b1;
            end
        end
`else
        speed_cycle = press_3;
`endif
    end

    // The prescaler advances only while the controller stays in RUN. On the
    // edge that pauses, it holds, so a later resume continues from there.
    assign run_adv    = (state_q == ST_RUN) && (state_next == ST_RUN);
    assign presc_last = PRE_W'((HALF_SECOND >> speed_q) - 1);

    // ------------------------------------------------------------- registers
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q <= ST_IDLE;
            speed_q <= '0;
            presc_q <= '0;
            tick_q  <= 1'b0;
            clear_q <= 1'b0;
        end else begin
            state_q <= state_next;
            clear_q <= (state_next == ST_CLEAR);
            tick_q  <= 1'b0;

            if (speed_cycle) begin
                // A speed change restarts the period, and it suppresses any
                // tick that would have fired on this edge.
                speed_q <= speed_inc(speed_q);
                presc_q <= '0;
            end else if (state_next == ST_IDLE || state_next == ST_CLEAR) begin
                presc_q <= '0;
            end else if (run_adv) begin
                if (presc_q == presc_last) begin
                    presc_q <= '0;
                    tick_q  <= 1'b1;
                end else begin
                    presc_q <= presc_q + PRE_W'(1);
                end
            end

            if (step_req) begin
                tick_q <= 1'b1;
            end
        end
    end

    assign o_Tick  = tick_q;
    assign o_Clear = clear_q;
    assign o_Speed = speed_q;
    assign o_State = state_q;

endmodule
